// File: rtl/anc_scheduler.sv
// Per-sample sequencer for the ANC datapath: lowpass -> NLMS -> FIR stage starts with stage timeout and overrun tracking.
// Optional feature macro ANC_SCHED_PENDING_EN: holds one busy-time sample request and launches it after the current sample.
module anc_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        sample_ready_in,
  input  logic        nc_on_in,
  input  logic        adapt_en_in,
  output logic        lp_start_out,
  input  logic        lp_done_in,
  output logic        lms_start_out,
  input  logic        lms_done_in,
  output logic        fir_start_out,
  input  logic        fir_done_in,
  output logic        sample_done_out,
  output logic        busy_out,
  output logic        overrun_out,
  output logic        timeout_out,
  output logic [15:0] overrun_count_out,
  output logic [2:0]  state_out
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LP   = 3'd1,
    ST_LMS  = 3'd2,
    ST_FIR  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d, ovr_cnt_d;
  logic             nc_q, nc_d, adapt_q, adapt_d;
  logic             lp_start_d, lms_start_d, fir_start_d, sample_done_d;
  logic             busy_d, overrun_d, timeout_d;
  logic             waiting, awaited_done, expired, launch, abort;
`ifdef ANC_SCHED_PENDING_EN
  logic             pend_q, pend_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    nc_d          = nc_q;
    adapt_d       = adapt_q;
    lp_start_d    = 1'b0;
    lms_start_d   = 1'b0;
    fir_start_d   = 1'b0;
    sample_done_d = 1'b0;
    overrun_d     = 1'b0;
    timeout_d     = 1'b0;
    ovr_cnt_d     = overrun_count_out;
    launch        = 1'b0;
    abort         = 1'b0;
    awaited_done  = 1'b0;
`ifdef ANC_SCHED_PENDING_EN
    pend_d        = pend_q;
`endif
    waiting = (state_q == ST_LP) || (state_q == ST_LMS) || (state_q == ST_FIR);
    expired = (wait_q >= WAIT_LIMIT);

    // Busy-time requests: park one if a pending slot exists, otherwise drop it
    if (waiting && sample_ready_in) begin
`ifdef ANC_SCHED_PENDING_EN
      if (!pend_q) pend_d = 1'b1;
      else         overrun_d = 1'b1;
`else
      overrun_d = 1'b1;
`endif
    end
    if (overrun_d && (overrun_count_out != CNT_MAX)) ovr_cnt_d = overrun_count_out + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
`ifdef ANC_SCHED_PENDING_EN
        launch = sample_ready_in || pend_q;
`else
        launch = sample_ready_in;
`endif
      end
      ST_LP: begin
        awaited_done = lp_done_in;
        if (lp_done_in) begin
          if (!nc_q) begin
            state_d       = ST_DONE;
            sample_done_d = 1'b1;
          end else if (adapt_q) begin
            state_d     = ST_LMS;
            lms_start_d = 1'b1;
          end else begin
            state_d     = ST_FIR;
            fir_start_d = 1'b1;
          end
        end
      end
      ST_LMS: begin
        awaited_done = lms_done_in;
        if (lms_done_in) begin
          state_d     = ST_FIR;
          fir_start_d = 1'b1;
        end
      end
      ST_FIR: begin
        awaited_done = fir_done_in;
        if (fir_done_in) begin
          state_d       = ST_DONE;
          sample_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifdef ANC_SCHED_PENDING_EN
        launch = sample_ready_in || pend_q;
`else
        launch = sample_ready_in;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // A done arriving on the limit cycle wins over the timeout
    if (waiting && !awaited_done && expired) begin
      abort     = 1'b1;
      timeout_d = 1'b1;
      state_d   = ST_IDLE;
`ifdef ANC_SCHED_PENDING_EN
      launch    = pend_q;
`endif
    end

    if (launch) begin
      state_d    = ST_LP;
      lp_start_d = 1'b1;
      nc_d       = nc_on_in;
      adapt_d    = adapt_en_in;
`ifdef ANC_SCHED_PENDING_EN
      pend_d     = !abort && pend_q && sample_ready_in;
`endif
    end

    busy_d = (state_d != ST_IDLE);
    wait_d = (waiting && (state_d == state_q)) ? wait_q + CNT_W'(1) : '0;
  end

  // State and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q           <= ST_IDLE;
      wait_q            <= '0;
      nc_q              <= 1'b0;
      adapt_q           <= 1'b0;
      lp_start_out      <= 1'b0;
      lms_start_out     <= 1'b0;
      fir_start_out     <= 1'b0;
      sample_done_out   <= 1'b0;
      busy_out          <= 1'b0;
      overrun_out       <= 1'b0;
      timeout_out       <= 1'b0;
      overrun_count_out <= '0;
`ifdef ANC_SCHED_PENDING_EN
      pend_q            <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      wait_q            <= wait_d;
      nc_q              <= nc_d;
      adapt_q           <= adapt_d;
      lp_start_out      <= lp_start_d;
      lms_start_out     <= lms_start_d;
      fir_start_out     <= fir_start_d;
      sample_done_out   <= sample_done_d;
      busy_out          <= busy_d;
      overrun_out       <= overrun_d;
      timeout_out       <= timeout_d;
      overrun_count_out <= ovr_cnt_d;
`ifdef ANC_SCHED_PENDING_EN
      pend_q            <= pend_d;
`endif
    end
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_anc_scheduler.sv
// Self-checking bench for anc_scheduler: table-driven sample sequences with a cycle-stamped event scoreboard.
module tb_anc_scheduler;

  localparam int unsigned T = 8;
  localparam logic [5:0] EV_LP = 6'h01, EV_LMS = 6'h02, EV_FIR = 6'h04;
  localparam logic [5:0] EV_DONE = 6'h08, EV_TO = 6'h10, EV_OVR = 6'h20;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        sample_ready_in = 1'b0, nc_on_in = 1'b0, adapt_en_in = 1'b0;
  logic        lp_done_in = 1'b0, lms_done_in = 1'b0, fir_done_in = 1'b0;
  logic        lp_start_out, lms_start_out, fir_start_out, sample_done_out;
  logic        busy_out, overrun_out, timeout_out;
  logic [15:0] overrun_count_out;
  logic [2:0]  state_out;

  always #5 clk_in = ~clk_in;

  anc_scheduler #(.TIMEOUT_CYCLES(T)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_ready_in(sample_ready_in),
    .nc_on_in(nc_on_in), .adapt_en_in(adapt_en_in),
    .lp_start_out(lp_start_out), .lp_done_in(lp_done_in),
    .lms_start_out(lms_start_out), .lms_done_in(lms_done_in),
    .fir_start_out(fir_start_out), .fir_done_in(fir_done_in),
    .sample_done_out(sample_done_out), .busy_out(busy_out),
    .overrun_out(overrun_out), .timeout_out(timeout_out),
    .overrun_count_out(overrun_count_out), .state_out(state_out)
  );

  typedef struct { int cyc; logic [5:0] ev; } exp_t;
  typedef struct {
    logic nc; logic ad;
    int d_lp; int d_lms; int d_fir;
    int c_lms; int c_fir; int c_done; int c_to;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b1;
  int   d_lp = 0, d_lms = 0, d_fir = 0;
  int   t_lp = 0, t_lms = 0, t_fir = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic [5:0] ev);
    exp_t e;
    e.cyc = c;
    e.ev  = ev;
    exp_q.push_back(e);
  endtask

  // One cycle: score observed events, run the stage responders, drive sample_ready
  task automatic step(input logic rdy);
    logic [5:0] ev;
    exp_t e;
    @(negedge clk_in);
    ev = {overrun_out, timeout_out, sample_done_out, fir_start_out, lms_start_out, lp_start_out};
    if (mon_en && ev != 6'h0) begin
      if (exp_q.size() == 0) check("unexpected_event", int'(ev), 0);
      else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_bits", int'(ev), int'(e.ev));
      end
    end
    lp_done_in  = (t_lp == 1);
    lms_done_in = (t_lms == 1);
    fir_done_in = (t_fir == 1);
    if (t_lp > 0) t_lp--;
    if (t_lms > 0) t_lms--;
    if (t_fir > 0) t_fir--;
    if (lp_start_out && d_lp > 0) t_lp = d_lp;
    if (lms_start_out && d_lms > 0) t_lms = d_lms;
    if (fir_start_out && d_fir > 0) t_fir = d_fir;
    sample_ready_in = rdy;
    cyc++;
  endtask

  task automatic run_vec(input vec_t v);
    nc_on_in = v.nc; adapt_en_in = v.ad;
    d_lp = v.d_lp; d_lms = v.d_lms; d_fir = v.d_fir;
    cyc = 0;
    push(1, EV_LP);
    if (v.c_lms != 0) push(v.c_lms, EV_LMS);
    if (v.c_fir != 0) push(v.c_fir, EV_FIR);
    if (v.c_done != 0) push(v.c_done, EV_DONE);
    if (v.c_to != 0) push(v.c_to, EV_TO);
    step(1'b1);
    step(1'b0);
    check("lp_state", int'(state_out), 1);
    check("lp_busy", int'(busy_out), 1);
    repeat (30) step(1'b0);
    check("queue_drained", exp_q.size(), 0);
    check("idle_state", int'(state_out), 0);
    check("idle_busy", int'(busy_out), 0);
    exp_q.delete();
  endtask

  initial begin
    // nc, ad, d_lp, d_lms, d_fir, lms@, fir@, done@, timeout@
    vecs[0] = '{1'b1, 1'b1, 3, 3, 3, 5, 9, 13, 0};
    vecs[1] = '{1'b0, 1'b1, 2, 0, 0, 0, 0, 4, 0};
    vecs[2] = '{1'b1, 1'b0, 4, 0, 2, 0, 6, 9, 0};
    vecs[3] = '{1'b1, 1'b1, 1, 1, 1, 3, 5, 7, 0};
    vecs[4] = '{1'b1, 1'b1, 3, 20, 3, 5, 0, 0, 13};
    vecs[5] = '{1'b0, 1'b0, 7, 0, 0, 0, 0, 9, 0};
    vecs[6] = '{1'b0, 1'b0, 8, 0, 0, 0, 0, 0, 9};
    vecs[7] = '{1'b1, 1'b0, 3, 0, 7, 0, 5, 13, 0};
    vecs[8] = '{1'b1, 1'b0, 3, 0, 8, 0, 5, 0, 13};

    repeat (2) @(negedge clk_in);
    check("rst_state", int'(state_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_lp_start", int'(lp_start_out), 0);
    check("rst_count", int'(overrun_count_out), 0);
    rst_in = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    check("no_overruns_yet", int'(overrun_count_out), 0);

`ifdef ANC_SCHED_PENDING_EN
    // Two requests during NLMS: first parked, second dropped, parked one launches after DONE
    nc_on_in = 1'b1; adapt_en_in = 1'b1; d_lp = 3; d_lms = 6; d_fir = 3; cyc = 0;
    push(1, EV_LP); push(5, EV_LMS); push(9, EV_OVR); push(12, EV_FIR);
    push(16, EV_DONE); push(17, EV_LP); push(21, EV_DONE);
    for (int c = 0; c < 40; c++) begin
      if (c == 10) nc_on_in = 1'b0;
      step(c == 0 || c == 6 || c == 8);
    end
    check("pend_queue_drained", exp_q.size(), 0);
    check("pend_count", int'(overrun_count_out), 1);
`else
    // Three drops during FIR, then back-to-back acceptance in DONE
    nc_on_in = 1'b1; adapt_en_in = 1'b0; d_lp = 2; d_lms = 0; d_fir = 7; cyc = 0;
    push(1, EV_LP); push(4, EV_FIR); push(6, EV_OVR); push(8, EV_OVR);
    push(10, EV_OVR); push(12, EV_DONE); push(13, EV_LP); push(16, EV_DONE);
    for (int c = 0; c < 40; c++) begin
      if (c == 11) nc_on_in = 1'b0;
      step(c == 0 || c == 5 || c == 7 || c == 9 || c == 12);
    end
    check("ovr_queue_drained", exp_q.size(), 0);
    check("ovr_count", int'(overrun_count_out), 3);
`endif
    exp_q.delete();

    // Asynchronous reset in the middle of FIR
    nc_on_in = 1'b1; adapt_en_in = 1'b1; d_lp = 1; d_lms = 1; d_fir = 5; cyc = 0;
    push(1, EV_LP); push(3, EV_LMS); push(5, EV_FIR);
    for (int c = 0; c < 8; c++) step(c == 0);
    #2 rst_in = 1'b1;
    #1;
    check("async_rst_state", int'(state_out), 0);
    check("async_rst_busy", int'(busy_out), 0);
    check("async_rst_done", int'(sample_done_out), 0);
    check("async_rst_timeout", int'(timeout_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (20) step(1'b0);
    check("rst_queue_drained", exp_q.size(), 0);
    run_vec(vecs[1]);

`ifndef ANC_SCHED_PENDING_EN
    // Counter saturation: ready held high keeps the scheduler cycling LP -> timeout
    rst_in = 1'b1;
    @(negedge clk_in);
    check("sat_rst_count", int'(overrun_count_out), 0);
    rst_in = 1'b0;
    mon_en = 1'b0; nc_on_in = 1'b1; adapt_en_in = 1'b0; d_lp = 0; d_lms = 0; d_fir = 0;
    repeat (73726) step(1'b1);
    step(1'b0);
    check("sat_preload", int'(overrun_count_out), 32'hFFFE);
    step(1'b0);
    step(1'b1);
    repeat (3) step(1'b1);
    step(1'b0);
    check("sat_hold", int'(overrun_count_out), 32'hFFFF);
    check("sat_pulse", int'(overrun_out), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anc_scheduler.md
ANC_SCHEDULER -- requirements
Module: anc_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles any stage may take to return its done before the sample is aborted (legal range 2..65535).
REQ-002 clk_in  input  1  system clock; all logic on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous and active-high.
REQ-004 sample_ready_in  input  1  one-cycle pulse: new audio sample available.
REQ-005 nc_on_in  input  1  noise cancellation enable; sampled on sample acceptance.
REQ-006 adapt_en_in  input  1  NLMS weight-update enable; sampled on sample acceptance.
REQ-007 lp_start_out  output  1  one-cycle start pulse to lowpass stage.
REQ-008 lp_done_in  input  1  lowpass done pulse.
REQ-009 lms_start_out  output  1  one-cycle start pulse to NLMS stage.
REQ-010 lms_done_in  input  1  NLMS done pulse.
REQ-011 fir_start_out  output  1  one-cycle start pulse to FIR stage.
REQ-012 fir_done_in  input  1  FIR done pulse.
REQ-013 sample_done_out  output  1  one-cycle pulse: sample fully processed.
REQ-014 busy_out  output  1  high whenever state is not IDLE.
REQ-015 overrun_out  output  1  one-cycle pulse: sample_ready_in dropped.
REQ-016 timeout_out  output  1  one-cycle pulse: sample aborted on stage timeout.
REQ-017 overrun_count_out  output  16  saturating count of dropped samples.
REQ-018 state_out  output  3  current state encoding: IDLE=0, LP=1, LMS=2, FIR=3, DONE=4.

Function
REQ-019 All outputs shall be registered.
REQ-020 IDLE: sample_ready_in -> LP; lp_start_out high the next cycle (1-cycle latency); nc_on_in/adapt_en_in latched.
REQ-021 LP: on lp_done_in -> LMS with lms_start_out if latched nc_on and adapt_en both 1; -> FIR with fir_start_out if nc_on=1, adapt_en=0; -> DONE if nc_on=0.
REQ-022 LMS: on lms_done_in -> FIR, fir_start_out pulsed on the next cycle.
REQ-023 FIR: on fir_done_in -> DONE.
REQ-024 DONE: sample_done_out high for exactly this one cycle; -> IDLE, or -> LP with lp_start_out if sample_ready_in is high in DONE (back-to-back acceptance, no overrun).
REQ-025 Done inputs arriving in a state not waiting for them shall be ignored.
REQ-026 Wait-cycle counter (16 bits) cleared on entry to LP/LMS/FIR, incremented each cycle without the awaited done; reaching TIMEOUT_CYCLES-1 without done -> IDLE, timeout_out pulsed, no sample_done_out.
REQ-027 Awaited done on the same cycle the counter hits its limit shall count as success, not timeout.
REQ-028 sample_ready_in in LP, LMS or FIR shall be dropped: overrun_out pulsed, overrun_count_out incremented, saturating at 16'hFFFF; state transitions on that cycle proceed unaffected.
REQ-029 At most one start output shall be high in any cycle.

Reset
REQ-030 rst_in high shall immediately force state IDLE and clear all outputs, counter, latched enables and any pending flag to 0.
REQ-031 Reset mid-sample shall abort without sample_done_out or timeout_out; first sample_ready_in after release starts a fresh sequence.

Configuration
REQ-032 Macro ANC_SCHED_PENDING_EN defined: one-deep pending flag; sample_ready_in while busy sets it (no overrun) unless already set (then overrun per REQ-028); on DONE or timeout-abort with flag set -> LP next cycle, flag cleared, enables re-sampled at launch.
REQ-033 Macro ANC_SCHED_PENDING_EN undefined: no pending flag; every busy-time sample_ready_in is an overrun per REQ-028.

Verification
REQ-034 nc_on=1, adapt_en=1, ready at cycle 0, each done returned 3 cycles after its start -> lp_start@1, lms_start@5, fir_start@9, sample_done@13, state back to 0@14.
REQ-035 nc_on=0 -> only lp_start pulses; sample_done 1 cycle after lp_done; lms_start and fir_start never high.
REQ-036 TIMEOUT_CYCLES=8, lms_done withheld -> timeout_out pulses 8 cycles after lms_start, state 0, no fir_start or sample_done.
REQ-037 Macro undefined, 3 sample_ready pulses during FIR -> 3 overrun_out pulses, overrun_count_out=3; preload 16'hFFFE plus 3 more -> holds 16'hFFFF.
REQ-038 Macro defined, 2 sample_ready pulses during LMS -> overrun_count_out=1, second sequence's lp_start 1 cycle after first sample_done.
REQ-039 rst_in asserted asynchronously mid-FIR -> state_out=0 and all outputs 0 before next clock edge; no sample_done after release.
